// File: rtl/priority_index_serializer.sv
// Accepts a multi-hot request vector via valid/ready and emits the index of every
// set bit, one per output transfer, lowest-first (or highest-first when MSB_FIRST=1).
module priority_index_serializer #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_seen
);

    typedef enum logic {IDLE, EMIT} state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_seen_q, zero_seen_d;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sel_onehot;
    logic             last;

    // Priority pick: the final match in the scan order wins, so scan from the
    // lowest-priority end toward the highest-priority end.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) idx = IDX_W'(i);
            end
        end
    end

    assign sel_onehot = ONE << idx;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign last       = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_seen_d = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = EMIT;
                    end else begin
                        zero_seen_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pending_d = pending_q & ~sel_onehot;
                    if (last) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    // pending is zero whenever IDLE, so idx and last decode to 0 there.
    assign out_idx   = idx;
    assign out_last  = last;
    assign zero_seen = zero_seen_q;

endmodule
